// File: rtl/apb4_timer_mc_if.sv
// APB4 bus bundle between the peripheral bus master and apb4_timer_mc.
// Purely combinational wiring, no latency.
// No backpressure: the slave side holds pready high.
interface apb4_timer_mc_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_timer_mc.sv
// CHANNELS independent prescaled up/down timers behind one APB4 slave; PWM outputs under TIMER_PWM_EN.
// Latency: writes commit at the access-phase edge, reads are combinational, flag/pwm lag the step by one cycle.
// Backpressure: none, pready is always 1 (zero wait states).
module apb4_timer_mc #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int PSC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  apb4_timer_mc_if.slave        apb,
  input  logic                  tick_i,
  output logic [CHANNELS-1:0]   irq_o,
  output logic [CHANNELS-1:0]   pwm_o
);
  localparam int IDX_W = ADDR_WIDTH - 5;

  typedef struct packed {
    logic                 en;
    logic                 periodic;
    logic                 down;
    logic                 irq_en;
    logic                 src;
    logic [PSC_WIDTH-1:0] psc;
    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [CNT_WIDTH-1:0] cmp;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 flag;
  } chan_t;

  chan_t            ch_q [CHANNELS];
  chan_t            ch_d [CHANNELS];
  logic [IDX_W-1:0] ch_idx;
  logic [4:0]       offs;
  logic             access;
  logic             dec_err;
  logic             wr_en;

  assign ch_idx      = apb.paddr[ADDR_WIDTH-1:5];
  assign offs        = apb.paddr[4:0];
  assign access      = apb.psel & apb.penable;
  assign dec_err     = (32'(ch_idx) >= 32'(CHANNELS)) || (offs >= 5'h14) || (offs[1:0] != 2'b00);
  assign wr_en       = access & apb.pwrite & ~dec_err;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & dec_err;

`ifdef TIMER_PWM_EN
  logic [CNT_WIDTH-1:0] duty_q [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_d [CHANNELS];
  logic [CHANNELS-1:0]  pwm_q;
  logic [CHANNELS-1:0]  pwm_d;

  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      duty_d[c] = duty_q[c];
      if (wr_en && (ch_idx == IDX_W'(c)) && (offs == 5'h10)) begin
        duty_d[c] = apb.pwdata[CNT_WIDTH-1:0];
      end
      pwm_d[c] = ch_q[c].en && (ch_q[c].cnt < duty_q[c]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q <= '0;
      for (int c = 0; c < CHANNELS; c++) duty_q[c] <= '0;
    end else begin
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
    end
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = '0;
`endif

  always_comb begin
    apb.prdata = '0;
    if (access && !dec_err) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_idx == IDX_W'(c)) begin
          case (offs)
            5'h00: apb.prdata = {16'(ch_q[c].psc), 11'd0, ch_q[c].src, ch_q[c].irq_en,
                                 ch_q[c].down, ch_q[c].periodic, ch_q[c].en};
            5'h04: apb.prdata = 32'(ch_q[c].cmp);
            5'h08: apb.prdata = 32'(ch_q[c].cnt);
            5'h0C: apb.prdata = {31'd0, ch_q[c].flag};
`ifdef TIMER_PWM_EN
            5'h10: apb.prdata = 32'(duty_q[c]);
`endif
            default: apb.prdata = '0;
          endcase
        end
      end
    end
  end

  // Step update first, bus write last: the write wins on CNT/CTRL, but a match still wins over W1C.
  always_comb begin
    logic sel;
    logic ev;
    logic step;
    logic hit;
    sel  = 1'b0;
    ev   = 1'b0;
    step = 1'b0;
    hit  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_d[c] = ch_q[c];
      sel  = wr_en && (ch_idx == IDX_W'(c));
      ev   = ch_q[c].en && (ch_q[c].src ? tick_i : 1'b1);
      step = ev && (ch_q[c].psc_cnt == ch_q[c].psc);
      hit  = step && (ch_q[c].down ? (ch_q[c].cnt == '0) : (ch_q[c].cnt == ch_q[c].cmp));
      if (ev) ch_d[c].psc_cnt = step ? '0 : ch_q[c].psc_cnt + 1'b1;
      if (hit) begin
        ch_d[c].flag = 1'b1;
        if (ch_q[c].periodic) ch_d[c].cnt = ch_q[c].down ? ch_q[c].cmp : '0;
        else                  ch_d[c].en  = 1'b0;
      end else if (step) begin
        ch_d[c].cnt = ch_q[c].down ? ch_q[c].cnt - 1'b1 : ch_q[c].cnt + 1'b1;
      end
      if (sel) begin
        case (offs)
          5'h00: begin
            ch_d[c].en       = apb.pwdata[0];
            ch_d[c].periodic = apb.pwdata[1];
            ch_d[c].down     = apb.pwdata[2];
            ch_d[c].irq_en   = apb.pwdata[3];
            ch_d[c].src      = apb.pwdata[4];
            ch_d[c].psc      = apb.pwdata[16 +: PSC_WIDTH];
            if (apb.pwdata[0] && !ch_q[c].en) ch_d[c].psc_cnt = '0;
          end
          5'h04: ch_d[c].cmp = apb.pwdata[CNT_WIDTH-1:0];
          5'h08: ch_d[c].cnt = apb.pwdata[CNT_WIDTH-1:0];
          5'h0C: if (apb.pwdata[0] && !hit) ch_d[c].flag = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    irq_o = '0;
    for (int c = 0; c < CHANNELS; c++) irq_o[c] = ch_q[c].flag & ch_q[c].irq_en;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) ch_q[c] <= '0;
    end else begin
      ch_q <= ch_d;
    end
  end
endmodule

// File: tb/tb_apb4_timer_mc.sv
// Directed + randomized bench for apb4_timer_mc against an integer-arithmetic timer model.
`timescale 1ns/1ps
module tb_apb4_timer_mc;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int PW = 16;
  localparam int AW = 12;
  localparam longint unsigned MOD = 64'd1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [CH-1:0] irq;
  logic [CH-1:0] pwm;

  apb4_timer_mc_if #(.ADDR_WIDTH(AW)) bus();

  apb4_timer_mc #(.CHANNELS(CH), .CNT_WIDTH(CW), .PSC_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .apb   (bus.slave),
    .tick_i(tick),
    .irq_o (irq),
    .pwm_o (pwm)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit live   = 0;

  bit              m_en[CH], m_per[CH], m_down[CH], m_ie[CH], m_src[CH], m_flag[CH], m_pwm[CH];
  int unsigned     m_psc[CH], m_pcnt[CH];
  longint unsigned m_cmp[CH], m_cnt[CH], m_duty[CH];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit addr_bad(logic [11:0] a);
    return (int'(a[11:5]) >= CH) || (a[4:0] >= 5'h14) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    int c;
    c = int'(a[11:5]);
    if (addr_bad(a)) return 32'd0;
    case (a[4:0])
      5'h00: return {16'(m_psc[c]), 11'd0, m_src[c], m_ie[c], m_down[c], m_per[c], m_en[c]};
      5'h04: return 32'(m_cmp[c]);
      5'h08: return 32'(m_cnt[c]);
      5'h0C: return {31'd0, m_flag[c]};
`ifdef TIMER_PWM_EN
      5'h10: return 32'(m_duty[c]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer rules, given the inputs seen during the cycle.
  task automatic model_edge(bit rv, bit wr, logic [11:0] a, logic [31:0] d, bit tk);
    bit was_en, stp, hit;
    if (rv) begin
      for (int c = 0; c < CH; c++) begin
        m_en[c] = 0; m_per[c] = 0; m_down[c] = 0; m_ie[c] = 0; m_src[c] = 0;
        m_flag[c] = 0; m_pwm[c] = 0; m_psc[c] = 0; m_pcnt[c] = 0;
        m_cmp[c] = 0; m_cnt[c] = 0; m_duty[c] = 0;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      was_en = m_en[c];
      stp = 0;
      hit = 0;
`ifdef TIMER_PWM_EN
      m_pwm[c] = m_en[c] && (m_cnt[c] < m_duty[c]);
`endif
      if (m_en[c] && (tk || !m_src[c])) begin
        if (m_pcnt[c] == m_psc[c]) begin stp = 1; m_pcnt[c] = 0; end
        else m_pcnt[c]++;
      end
      if (stp) hit = m_down[c] ? (m_cnt[c] == 0) : (m_cnt[c] == m_cmp[c]);
      if (hit) begin
        m_flag[c] = 1;
        if (m_per[c]) m_cnt[c] = m_down[c] ? m_cmp[c] : 0;
        else          m_en[c]  = 0;
      end else if (stp) begin
        m_cnt[c] = m_down[c] ? (m_cnt[c] + MOD - 1) % MOD : (m_cnt[c] + 1) % MOD;
      end
      if (wr && !addr_bad(a) && int'(a[11:5]) == c) begin
        case (int'(a[4:0]))
          0: begin
            m_en[c] = d[0]; m_per[c] = d[1]; m_down[c] = d[2]; m_ie[c] = d[3]; m_src[c] = d[4];
            m_psc[c] = int'(d[31:16]);
            if (d[0] && !was_en) m_pcnt[c] = 0;
          end
          4:  m_cmp[c] = d;
          8:  m_cnt[c] = d;
          12: if (d[0] && !hit) m_flag[c] = 0;
`ifdef TIMER_PWM_EN
          16: m_duty[c] = d;
`endif
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    bit wr;
    logic [11:0] a;
    logic [31:0] d;
    bit tk, rv;
    wr = bus.psel && bus.penable && bus.pwrite;
    a  = bus.paddr;
    d  = bus.pwdata;
    tk = tick;
    rv = rst;
    @(posedge clk);
    model_edge(rv, wr, a, d, tk);
    #1;
    if (live) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("irq%0d", c), irq[c], m_flag[c] && m_ie[c]);
        chk($sformatf("pwm%0d", c), pwm[c], m_pwm[c]);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic apb_wr(logic [11:0] a, logic [31:0] d);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = a; bus.pwdata = d;
    cycle();
    bus.penable = 1;
    #1;
    chk("wr_pslverr", bus.pslverr, addr_bad(a));
    cycle();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic apb_rd(logic [11:0] a, string tag, output logic [31:0] v);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a;
    cycle();
    bus.penable = 1;
    #1;
    v = bus.prdata;
    chk(tag, bus.prdata, model_read(a));
    chk({tag, "_err"}, bus.pslverr, addr_bad(a));
    cycle();
    bus.psel = 0; bus.penable = 0;
  endtask

  initial begin
    logic [31:0] v;
    int hi;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;

    rst = 1; idle(3); rst = 0; live = 1;
    chk("pready", bus.pready, 1'b1);
    chk("irq_rst", irq, '0);
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < 5; o++) begin
        apb_rd(12'(c * 32 + o * 4), "rst_rd", v);
        chk("rst_zero", v, 0);
      end

    // ch0: up periodic, CMP=4, psc=0, clk source, irq enabled
    apb_wr(12'h004, 32'd4);
    apb_wr(12'h000, 32'h0000_000B);
    idle(4); chk("ch0_before_hit", irq[0], 1'b0);
    idle(1); chk("ch0_hit", irq[0], 1'b1);
    idle(7);

    // ch1: down one-shot from 3, psc=1, tick source, tick every third cycle
    apb_wr(12'h028, 32'd3);
    apb_wr(12'h024, 32'd3);
    apb_wr(12'h020, 32'h0001_0015);
    repeat (7) begin cycle(); cycle(); tick = 1; cycle(); tick = 0; end
    apb_rd(12'h02C, "ch1_stat7", v); chk("ch1_no_flag_7ticks", v, 0);
    cycle(); cycle(); tick = 1; cycle(); tick = 0;
    idle(1);
    apb_rd(12'h02C, "ch1_stat8", v); chk("ch1_flag_8ticks", v, 1);
    apb_rd(12'h020, "ch1_ctrl", v);  chk("ch1_en_cleared", v, 32'h0001_0014);
    apb_rd(12'h028, "ch1_cnt", v);   chk("ch1_cnt_held", v, 0);

    // ch2: W1C lands on the same edge as the one-shot match
    apb_wr(12'h044, 32'd3);
    apb_wr(12'h040, 32'h0000_0009);
    idle(2);
    apb_wr(12'h04C, 32'd1);
    chk("ch2_irq_after_race", irq[2], 1'b1);
    apb_rd(12'h04C, "ch2_stat", v); chk("ch2_flag_wins", v, 1);
    apb_wr(12'h04C, 32'd1);
    chk("ch2_irq_cleared", irq[2], 1'b0);
    apb_rd(12'h04C, "ch2_stat2", v); chk("ch2_flag_clr", v, 0);

    // decode errors leave every register alone
    apb_rd(12'h080, "bad80", v); chk("bad80_data", v, 0);
    apb_wr(12'h080, 32'hFFFF_FFFF);
    apb_wr(12'h014, 32'hFFFF_FFFF);
    apb_wr(12'h001, 32'hFFFF_FFFF);
    apb_rd(12'h014, "bad14", v);  chk("bad14_data", v, 0);
    apb_rd(12'h004, "ch0_cmp", v); chk("ch0_cmp_kept", v, 4);
    apb_rd(12'h000, "ch0_ctrl", v); chk("ch0_ctrl_kept", v, 32'h0000_000B);

    // ch3 PWM: CMP=9, DUTY=3
    apb_wr(12'h064, 32'd9);
    apb_wr(12'h070, 32'd3);
    apb_wr(12'h060, 32'h0000_0003);
    idle(12);
    hi = 0;
    repeat (20) begin cycle(); hi += int'(pwm[3]); end
`ifdef TIMER_PWM_EN
    chk("pwm_duty3_highs", hi, 6);
    apb_wr(12'h070, 32'd0);
    idle(2);
    hi = 0;
    repeat (20) begin cycle(); hi += int'(pwm[3]); end
    chk("pwm_duty0_highs", hi, 0);
`else
    chk("pwm_off_highs", hi, 0);
    apb_rd(12'h070, "duty_off", v); chk("duty_reads0", v, 0);
`endif

    // reset while channels are counting
    rst = 1; cycle(); rst = 0;
    for (int c = 0; c < CH; c++) begin
      apb_rd(12'(c * 32 + 8), "midrst_cnt", v); chk("midrst_cnt0", v, 0);
      apb_rd(12'(c * 32), "midrst_ctrl", v);    chk("midrst_ctrl0", v, 0);
    end

    // randomized configuration and traffic; ch0 also crosses the counter wrap
    for (int c = 0; c < CH; c++) begin
      logic [31:0] ctl;
      apb_wr(12'(c * 32 + 4), 32'($urandom_range(0, 6)));
      apb_wr(12'(c * 32 + 8), (c == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8)));
      apb_wr(12'(c * 32 + 16), 32'($urandom_range(0, 7)));
      ctl = {16'($urandom_range(0, 2)), 11'd0, 5'($urandom) | 5'd1};
      if (c == 0) ctl = 32'h0000_000B;
      apb_wr(12'(c * 32), ctl);
    end
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) tick = 0;
      else tick = !tick && ($urandom_range(0, 2) == 0);
      case (op)
        0: apb_rd(12'($urandom_range(0, 4) * 32 + $urandom_range(0, 7) * 4), "rnd_rd", v);
        1: apb_wr(12'($urandom_range(0, CH - 1) * 32 + 12), 32'd1);
        2: begin
          int c;
          c = $urandom_range(0, CH - 1);
          apb_wr(12'(c * 32), {16'($urandom_range(0, 2)), 11'd0, 5'($urandom)});
        end
        default: cycle();
      endcase
    end
    tick = 0;
    for (int c = 0; c < CH; c++) begin
      apb_rd(12'(c * 32 + 8), "end_cnt", v);
      apb_rd(12'(c * 32 + 12), "end_stat", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
